// File: rtl/sram_responder_pkg.sv
// Shared encodings and defaults for the SRAM responder and its link register.
package sram_responder_pkg;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_FINISH} state_t;

  localparam int DEF_READ_WAIT  = 2;
  localparam int DEF_WRITE_WAIT = 2;
  localparam int CNT_W          = 16;

  localparam logic [31:0] SC_OK   = 32'h1;
  localparam logic [31:0] SC_FAIL = 32'h0;
endpackage

// File: rtl/sram_responder_link_reg.sv
// LL/SC reservation: one word address plus a valid flag; any clear beats a set.
module sram_link_reg #(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic [ADDR_W-1:0] cmp_addr,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic              hit
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (set) begin
      valid <= 1'b1;
      addr  <= set_addr;
    end
  end

  assign hit = valid && (addr == cmp_addr);
endmodule

// File: rtl/sram_responder.sv
// Bus-to-async-SRAM responder: one transaction at a time, programmable wait states, LL/SC link.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int READ_WAIT  = DEF_READ_WAIT,
  parameter int WRITE_WAIT = DEF_WRITE_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_sel,
  input  logic              mem_en,
  input  logic              mem_wen_n,
  input  logic              ll_i,
  input  logic              sc_i,
  input  logic              link_clear,
  output logic [31:0]       mem_rdata,
  output logic              done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dq_o,
  input  logic [31:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_WAIT + 1);
  localparam logic [CNT_W-1:0] WE_END  = CNT_W'(WRITE_WAIT);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              ll_q, sc_q;
  logic              link_valid, link_hit, link_set, link_clr;
  logic [ADDR_W-1:0] link_addr, req_word;
  logic              rd_last, wr_last, sc_miss;
  logic              unused_addr_bits;

  assign req_word         = mem_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

  assign rd_last  = (state == S_READ) && mem_en && (cnt == RD_LAST);
  assign wr_last  = (state == S_WRITE) && (cnt == WR_LAST);
  assign sc_miss  = (state == S_IDLE) && mem_en && !mem_wen_n && sc_i && !link_hit;
  assign link_set = rd_last && ll_q;
  // Any SC ends the reservation, as does a plain write landing on the linked word.
  assign link_clr = link_clear || sc_miss ||
                    (wr_last && (sc_q || (link_addr == sram_addr)));

  sram_link_reg #(.ADDR_W(ADDR_W)) u_link (
    .clk     (clk),
    .rst     (rst),
    .clr     (link_clr),
    .set     (link_set),
    .set_addr(sram_addr),
    .cmp_addr(req_word),
    .valid   (link_valid),
    .addr    (link_addr),
    .hit     (link_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ll_q       <= 1'b0;
      sc_q       <= 1'b0;
      done       <= 1'b0;
      mem_rdata  <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_en) begin
            sram_addr <= req_word;
            sram_dq_o <= mem_wdata;
            ll_q      <= ll_i;
            sc_q      <= sc_i;
            cnt       <= '0;
            if (mem_wen_n) begin
              state     <= S_READ;
              sram_ce_n <= 1'b0;
              sram_oe_n <= 1'b0;
              sram_be_n <= 4'h0;
            end else if (!sc_i || link_hit) begin
              state      <= S_WRITE;
              sram_ce_n  <= 1'b0;
              sram_dq_oe <= 1'b1;
              sram_be_n  <= mem_sel;
            end else begin
              state     <= S_FINISH;
              done      <= 1'b1;
              mem_rdata <= SC_FAIL;
            end
          end
        end
        S_READ: begin
          if (!mem_en || rd_last) begin
            state     <= mem_en ? S_FINISH : S_IDLE;
            done      <= mem_en;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_be_n <= 4'hF;
            if (mem_en) mem_rdata <= sram_dq_i;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WRITE: begin
          if (wr_last) begin
            state      <= S_FINISH;
            done       <= 1'b1;
            sram_ce_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            sram_be_n  <= 4'hF;
            if (sc_q) mem_rdata <= SC_OK;
          end else begin
            cnt <= cnt + 1'b1;
            // we_n for the next cycle: low after the setup cycle, high again for the hold cycle.
            sram_we_n <= (cnt >= WE_END);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: expected read/SC data queued at issue, popped at done.
module tb_sram_responder;
  localparam int AW = 20, RW = 2, WW = 2, BUDGET = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   mem_addr = '0, mem_wdata = '0, sram_dq_i = '0;
  logic [3:0]    mem_sel = 4'h0;
  logic          mem_en = 1'b0, mem_wen_n = 1'b1, ll_i = 1'b0, sc_i = 1'b0, link_clear = 1'b0;
  logic [31:0]   mem_rdata, sram_dq_o;
  logic          done, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [AW-1:0] sram_addr;
  logic [3:0]    sram_be_n;

  sram_responder #(.ADDR_W(AW), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel(mem_sel),
    .mem_en(mem_en), .mem_wen_n(mem_wen_n), .ll_i(ll_i), .sc_i(sc_i), .link_clear(link_clear),
    .mem_rdata(mem_rdata), .done(done), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
    .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rdata = '0;
  logic        mlink_v = 1'b0;
  logic [AW-1:0] mlink_a = '0;
  logic        tr_we[0:BUDGET], tr_oe[0:BUDGET], tr_ce[0:BUDGET], tr_dqoe[0:BUDGET];
  logic [3:0]  tr_be[0:BUDGET];

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drives one request, records strobes per cycle T+k, returns the done cycle and data.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s,
                         input logic wn, input logic l, input logic c, input logic [31:0] dq,
                         output int dcyc, output logic [31:0] rd, output logic done_after);
    mem_addr = a; mem_wdata = wd; mem_sel = s; mem_wen_n = wn; ll_i = l; sc_i = c;
    sram_dq_i = dq; mem_en = 1'b1;
    dcyc = -1; rd = 'x;
    for (int k = 1; k <= BUDGET; k++) begin
      step();
      tr_we[k] = sram_we_n; tr_oe[k] = sram_oe_n; tr_ce[k] = sram_ce_n;
      tr_dqoe[k] = sram_dq_oe; tr_be[k] = sram_be_n;
      if (done === 1'b1) begin
        dcyc = k; rd = mem_rdata;
        break;
      end
    end
    mem_en = 1'b0; ll_i = 1'b0; sc_i = 1'b0;
    step();
    done_after = done;
  endtask

  function automatic int count_we_low(input int dcyc);
    int n = 0;
    int last = (dcyc > 0) ? dcyc : BUDGET;
    for (int k = 1; k <= last; k++) if (tr_we[k] === 1'b0) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", mem_rdata); end
    checks++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_be_n} !== 8'hEF) begin
      errors++; $display("FAIL reset_strobes got %h want ef", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_be_n});
    end
    checks++; if (sram_addr !== '0 || sram_dq_o !== '0) begin
      errors++; $display("FAIL reset_addr_dq got %h/%h want 0/0", sram_addr, sram_dq_o);
    end
    checks++; if (dut.link_valid !== 1'b0) begin errors++; $display("FAIL reset_link got %b want 0", dut.link_valid); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_read();
    int dcyc; logic [31:0] rd, exp; logic da;
    exp_q.push_back(32'hDEADBEEF);
    run_txn(32'h10, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, dcyc, rd, da);
    model_rdata = 32'hDEADBEEF;
    exp = exp_q.pop_front();
    checks++; if (dcyc !== RW + 1) begin errors++; $display("FAIL read_done_cycle got %0d want %0d", dcyc, RW + 1); end
    checks++; if (rd !== exp) begin errors++; $display("FAIL read_data got %h want %h", rd, exp); end
    checks++; if (sram_addr !== 20'h4) begin errors++; $display("FAIL read_addr got %h want 4", sram_addr); end
    for (int k = 1; k <= RW; k++) begin
      checks++; if ({tr_ce[k], tr_oe[k], tr_dqoe[k], tr_be[k]} !== 7'b0) begin
        errors++; $display("FAIL read_strobe_c%0d got %b want 0000000", k, {tr_ce[k], tr_oe[k], tr_dqoe[k], tr_be[k]});
      end
    end
    checks++; if (tr_oe[RW + 1] !== 1'b1) begin errors++; $display("FAIL read_oe_release got %b want 1", tr_oe[RW + 1]); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL read_done_width got %b want 0", da); end
  endtask

  task automatic test_byte_write();
    int dcyc; logic [31:0] rd, exp; logic da;
    exp_q.push_back(model_rdata);
    run_txn(32'h8, 32'h0000_00AB, 4'b1110, 1'b0, 1'b0, 1'b0, 32'h0, dcyc, rd, da);
    exp = exp_q.pop_front();
    checks++; if (dcyc !== WW + 3) begin errors++; $display("FAIL bw_done_cycle got %0d want %0d", dcyc, WW + 3); end
    checks++; if (rd !== exp) begin errors++; $display("FAIL bw_rdata_kept got %h want %h", rd, exp); end
    checks++; if (sram_dq_o !== 32'hAB || sram_addr !== 20'h2) begin
      errors++; $display("FAIL bw_dq_addr got %h/%h want 000000ab/2", sram_dq_o, sram_addr);
    end
    for (int k = 1; k <= WW + 2; k++) begin
      logic exp_we;
      exp_we = !(k >= 2 && k <= WW + 1);
      checks++; if ({tr_be[k], tr_we[k], tr_dqoe[k], tr_oe[k], tr_ce[k]} !== {4'b1110, exp_we, 3'b110}) begin
        errors++; $display("FAIL bw_strobe_c%0d got %b want %b", k,
          {tr_be[k], tr_we[k], tr_dqoe[k], tr_oe[k], tr_ce[k]}, {4'b1110, exp_we, 3'b110});
      end
    end
    checks++; if (tr_dqoe[WW + 3] !== 1'b0) begin errors++; $display("FAIL bw_dqoe_release got %b want 0", tr_dqoe[WW + 3]); end
  endtask

  task automatic test_ll_sc();
    int dcyc, exp_cyc; logic [31:0] rd, exp; logic da, hit;
    exp_q.push_back(32'h1234_5678);
    run_txn(32'h100, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h1234_5678, dcyc, rd, da);
    mlink_v = 1'b1; mlink_a = 20'h40; model_rdata = 32'h1234_5678;
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL ll_data got %h want %h", rd, exp); end
    checks++; if (dut.link_valid !== mlink_v) begin errors++; $display("FAIL ll_link_set got %b want %b", dut.link_valid, mlink_v); end
    for (int pass = 0; pass < 2; pass++) begin
      hit = mlink_v && (mlink_a == 20'h40);
      exp_q.push_back(hit ? 32'h1 : 32'h0);
      exp_cyc = hit ? WW + 3 : 1;
      run_txn(32'h100, 32'h55, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0, dcyc, rd, da);
      mlink_v = 1'b0; model_rdata = hit ? 32'h1 : 32'h0;
      exp = exp_q.pop_front();
      checks++; if (rd !== exp) begin errors++; $display("FAIL sc%0d_result got %h want %h", pass, rd, exp); end
      checks++; if (dcyc !== exp_cyc) begin errors++; $display("FAIL sc%0d_done_cycle got %0d want %0d", pass, dcyc, exp_cyc); end
      checks++; if (count_we_low(dcyc) !== (hit ? WW : 0)) begin
        errors++; $display("FAIL sc%0d_we_cycles got %0d want %0d", pass, count_we_low(dcyc), hit ? WW : 0);
      end
      checks++; if (dut.link_valid !== 1'b0) begin errors++; $display("FAIL sc%0d_link_clear got %b want 0", pass, dut.link_valid); end
    end
  endtask

  task automatic test_link_kill();
    int dcyc; logic [31:0] rd, exp; logic da;
    for (int mode = 0; mode < 2; mode++) begin
      exp_q.push_back(32'h0BAD_F00D);
      run_txn(32'h200, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h0BAD_F00D, dcyc, rd, da);
      mlink_v = 1'b1; mlink_a = 20'h80; model_rdata = 32'h0BAD_F00D;
      exp = exp_q.pop_front();
      checks++; if (rd !== exp) begin errors++; $display("FAIL kill%0d_ll_data got %h want %h", mode, rd, exp); end
      if (mode == 0) begin
        exp_q.push_back(model_rdata);
        run_txn(32'h200, 32'h77, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, dcyc, rd, da);
        exp = exp_q.pop_front();
        checks++; if (rd !== exp) begin errors++; $display("FAIL kill_write_rdata got %h want %h", rd, exp); end
      end else begin
        link_clear = 1'b1; step(); link_clear = 1'b0;
      end
      mlink_v = 1'b0;
      checks++; if (dut.link_valid !== mlink_v) begin errors++; $display("FAIL kill%0d_link got %b want 0", mode, dut.link_valid); end
      exp_q.push_back(32'h0);
      run_txn(32'h200, 32'h66, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0, dcyc, rd, da);
      model_rdata = 32'h0;
      exp = exp_q.pop_front();
      checks++; if (rd !== exp || dcyc !== 1) begin
        errors++; $display("FAIL kill%0d_sc got %h@%0d want %h@1", mode, rd, dcyc, exp);
      end
      checks++; if (tr_ce[1] !== 1'b1 || tr_we[1] !== 1'b1) begin
        errors++; $display("FAIL kill%0d_sc_idle got ce=%b we=%b want 1/1", mode, tr_ce[1], tr_we[1]);
      end
    end
  endtask

  task automatic test_read_abort();
    int dcyc; logic [31:0] rd, exp; logic da;
    mem_addr = 32'h40; mem_wen_n = 1'b1; ll_i = 1'b1; sc_i = 1'b0; sram_dq_i = 32'hCAFE_F00D; mem_en = 1'b1;
    step();
    checks++; if (sram_oe_n !== 1'b0) begin errors++; $display("FAIL abort_started got oe_n=%b want 0", sram_oe_n); end
    mem_en = 1'b0; ll_i = 1'b0;
    step();
    checks++; if ({sram_ce_n, sram_oe_n, sram_we_n, done} !== 4'b1110) begin
      errors++; $display("FAIL abort_release got %b want 1110", {sram_ce_n, sram_oe_n, sram_we_n, done});
    end
    step();
    checks++; if (done !== 1'b0 || mem_rdata !== model_rdata) begin
      errors++; $display("FAIL abort_no_capture got %b/%h want 0/%h", done, mem_rdata, model_rdata);
    end
    checks++; if (dut.link_valid !== 1'b0) begin errors++; $display("FAIL abort_no_link got %b want 0", dut.link_valid); end
    exp_q.push_back(32'h600D_CAFE);
    run_txn(32'h44, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h600D_CAFE, dcyc, rd, da);
    model_rdata = 32'h600D_CAFE;
    exp = exp_q.pop_front();
    checks++; if (rd !== exp || dcyc !== RW + 1) begin
      errors++; $display("FAIL abort_next_read got %h@%0d want %h@%0d", rd, dcyc, exp, RW + 1);
    end
  endtask

  task automatic test_reset_mid_write();
    int dcyc; logic [31:0] rd, exp; logic da;
    exp_q.push_back(32'h1111_2222);
    run_txn(32'h300, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 32'h1111_2222, dcyc, rd, da);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp || dut.link_valid !== 1'b1) begin
      errors++; $display("FAIL rmw_ll got %h/%b want %h/1", rd, dut.link_valid, exp);
    end
    mem_addr = 32'h304; mem_wdata = 32'h99; mem_sel = 4'h0; mem_wen_n = 1'b0; mem_en = 1'b1;
    step(); step();
    checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL rmw_mid_write got we_n=%b want 0", sram_we_n); end
    rst = 1'b1;
    step();
    checks++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_be_n} !== 8'hEF || done !== 1'b0) begin
      errors++; $display("FAIL rmw_strobes got %h done=%b want ef done=0",
        {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_be_n}, done);
    end
    checks++; if (dut.link_valid !== 1'b0 || mem_rdata !== 32'h0) begin
      errors++; $display("FAIL rmw_state got link=%b rdata=%h want 0/0", dut.link_valid, mem_rdata);
    end
    rst = 1'b0; mem_en = 1'b0; mlink_v = 1'b0; model_rdata = 32'h0;
    step();
    exp_q.push_back(32'h3141_5926);
    run_txn(32'h8, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h3141_5926, dcyc, rd, da);
    model_rdata = 32'h3141_5926;
    exp = exp_q.pop_front();
    checks++; if (rd !== exp || dcyc !== RW + 1) begin
      errors++; $display("FAIL rmw_recover got %h@%0d want %h@%0d", rd, dcyc, exp, RW + 1);
    end
  endtask

  task automatic test_back_to_back();
    int dcyc, exp_cyc; logic [31:0] rd, exp, dq; logic da, wn;
    for (int i = 0; i < 8; i++) begin
      wn = i[0];
      dq = $urandom;
      if (wn) exp_q.push_back(dq); else exp_q.push_back(model_rdata);
      exp_cyc = wn ? RW + 1 : WW + 3;
      run_txn({20'h0, 10'($urandom_range(0, 1023)), 2'b00}, $urandom, 4'($urandom_range(0, 15)),
              wn, 1'b0, 1'b0, dq, dcyc, rd, da);
      if (wn) model_rdata = dq;
      exp = exp_q.pop_front();
      checks++; if (rd !== exp || dcyc !== exp_cyc) begin
        errors++; $display("FAIL b2b_%0d got %h@%0d want %h@%0d", i, rd, dcyc, exp, exp_cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_byte_write();
    test_ll_sc();
    test_link_kill();
    test_read_abort();
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
